// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix feeder: default element width and matrix
// dimensions, the feeder state encoding, and a helper that sizes the host
// element counter.
// No ports (package).
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_M  = 4;
  localparam int DEF_N  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD1 = 2'd1,
    LOAD2 = 2'd2,
    DONE  = 2'd3
  } feederState_t;

  // Width able to hold the full element count 2*m*n of one transfer
  function automatic int countWidth(input int m, input int n);
    return $clog2(2 * m * n) + 1;
  endfunction

endpackage

// File: rtl/matrix_feeder_idx_counter.sv
// ---------------------------------------------------------------------------
// idx_counter
// Row/column position pair. Column counts up to lastCol, then wraps to 0 and
// bumps the row; the row wraps after lastRow. clear has priority over advance.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             force row/col to 0
//   advance           step to the next position
//   lastRow, lastCol  highest row / column index of the current matrix
//   row, col          current position
//   atEnd             current position is (lastRow, lastCol)
// ---------------------------------------------------------------------------
module idx_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] lastRow,
  input  logic [W-1:0] lastCol,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         atEnd
);

  assign atEnd = (row == lastRow) && (col == lastCol);

  // Row-major stepping with wrap on both coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == lastCol) begin
        col <= '0;
        row <= (row == lastRow) ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_feeder.sv
// ---------------------------------------------------------------------------
// matrix_feeder
// Streams two matrices from a host into a multiplier through a one-entry
// holding register. Matrix1 (M x N) goes first, then matrix2 (N x M), both
// row-major; rowIdx/colIdx give the position of the element on outData.
// Optional feature: define FEEDER_ABORT_EN to add the abort input.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a transfer (only honoured in IDLE)
//   inElem, inValid     host element and its valid
//   inReady             feeder takes inElem this cycle
//   outData, outValid   held element towards the multiplier
//   outAccept           multiplier consumes outData this cycle
//   mat2Sel             0 = matrix1 phase, 1 = matrix2 phase
//   rowIdx, colIdx      position of the held element
//   busy                high in LOAD1, LOAD2 and DONE
//   done                one-cycle pulse when a transfer completes
//   abort               (FEEDER_ABORT_EN only) cancel the running transfer
// ---------------------------------------------------------------------------
module matrix_feeder
  import matrix_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int M  = DEF_M,
  parameter int N  = DEF_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] inElem,
  input  logic          inValid,
  output logic          inReady,
  output logic [DW-1:0] outData,
  output logic          outValid,
  input  logic          outAccept,
  output logic          mat2Sel,
  output logic [DW-1:0] rowIdx,
  output logic [DW-1:0] colIdx,
  output logic          busy,
  output logic          done
`ifdef FEEDER_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam int             CW    = countWidth(M, N);
  localparam logic [CW-1:0]  TOTAL = CW'(2 * M * N);

  feederState_t  state;
  logic [CW-1:0] hostCount;
  logic          phaseActive;
  logic          hostHs;
  logic          outHs;
  logic          atEnd;
  logic          idxClear;
  logic          idxAdvance;
  logic [DW-1:0] lastRow;
  logic [DW-1:0] lastCol;

  assign phaseActive = (state == LOAD1) || (state == LOAD2);

  // A slot is free when nothing is held or the held element leaves this cycle
  assign inReady = phaseActive && (hostCount < TOTAL) && (!outValid || outAccept);
  assign hostHs  = inValid && inReady;
  assign outHs   = outValid && outAccept;

  // Matrix1 is M x N, matrix2 is N x M
  assign lastRow = mat2Sel ? DW'(N - 1) : DW'(M - 1);
  assign lastCol = mat2Sel ? DW'(M - 1) : DW'(N - 1);

  assign idxAdvance = outHs && phaseActive;
`ifdef FEEDER_ABORT_EN
  assign idxClear = (state == IDLE) || (outHs && atEnd) || (phaseActive && abort);
`else
  assign idxClear = (state == IDLE) || (outHs && atEnd);
`endif

  idx_counter #(
    .W(DW)
  ) idxCounter (
    .clk     (clk),
    .rst     (rst),
    .clear   (idxClear),
    .advance (idxAdvance),
    .lastRow (lastRow),
    .lastCol (lastCol),
    .row     (rowIdx),
    .col     (colIdx),
    .atEnd   (atEnd)
  );

  // Transfer FSM plus the holding register. A host load wins over a drain so
  // a simultaneous consume/load keeps outValid high with no bubble. The phase
  // changes on the handshake of the last element of the current matrix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      outData   <= '0;
      outValid  <= 1'b0;
      mat2Sel   <= 1'b0;
      hostCount <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD1;
            busy      <= 1'b1;
            mat2Sel   <= 1'b0;
            hostCount <= '0;
            outValid  <= 1'b0;
          end
        end
        LOAD1, LOAD2: begin
          if (hostHs) begin
            outData   <= inElem;
            outValid  <= 1'b1;
            hostCount <= hostCount + CW'(1);
          end else if (outHs) begin
            outValid <= 1'b0;
          end
          if (outHs && atEnd) begin
            if (state == LOAD1) begin
              state   <= LOAD2;
              mat2Sel <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
`ifdef FEEDER_ABORT_EN
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            outValid  <= 1'b0;
            hostCount <= '0;
            mat2Sel   <= 1'b0;
            done      <= 1'b0;
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mat2Sel   <= 1'b0;
          hostCount <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
